apb_multi_manager: RTL and testbench



---
 rtl/apb_multi_manager_if.sv | 27 ++
 rtl/apb_multi_manager.sv | 173 +++++++++++++++++
 tb/tb_apb_multi_manager.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_multi_manager_if.sv
// APB requester bundle: address/control driven by the manager,
// per-completer PREADY/PSLVERR and shared PRDATA returned to it.
// Modports: master = requester side, slave = completer side.
interface apb_multi_manager_if #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [ADDR_W-1:0]  PADDR;
  logic               PWRITE;
  logic [DATA_W-1:0]  PWDATA;
  logic               PENABLE;
  logic [NUM_SLV-1:0] PSEL;
  logic [DATA_W-1:0]  PRDATA;
  logic [NUM_SLV-1:0] PREADY;
  logic [NUM_SLV-1:0] PSLVERR;

  modport master (
    output PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PWDATA, PENABLE, PSEL,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_manager.sv
// APB requester fed by a request FIFO and returning {err, rdata} to a
// response FIFO; one transfer in flight, completer picked by top addr bits.
// Ports: PCLK, PRESET (sync, active-high); req_data/req_empty/req_rreq;
// resp_data/resp_full/resp_wreq; busy; apb (master modport).
// Optional macro APB_MGR_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYC waits.
module apb_multi_manager #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic [DATA_W+ADDR_W:0] req_data,
  input  logic                   req_empty,
  output logic                   req_rreq,
  output logic [DATA_W+1:0]      resp_data,
  input  logic                   resp_full,
  output logic                   resp_wreq,
  output logic                   busy,
  apb_multi_manager_if.master    apb
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SEL_W:0] SLV_LIM = (SEL_W+1)'(NUM_SLV);

  typedef enum logic [2:0] {
    IDLE, FETCH, SETUP, ACCESS, RESP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;

`ifdef APB_MGR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [SEL_W-1:0]    idx;
  logic                dec_ok;
  logic [NUM_SLV-1:0]  sel_oh;
  logic                rdy;
  logic                slverr;

  logic                rreq_c, wreq_c, pen_c, pwr_c;
  logic [DATA_W+1:0]   resp_c;
  logic [NUM_SLV-1:0]  psel_c;
  logic [ADDR_W-1:0]   paddr_c;
  logic [DATA_W-1:0]   pwdata_c;

  assign idx    = addr_q[ADDR_W-1 -: SEL_W];
  assign dec_ok = {1'b0, idx} < SLV_LIM;

  always_comb begin
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_oh[i] = (idx == SEL_W'(i));
    end
  end

  // masking keeps non-selected completers out of the decision
  assign rdy    = |(apb.PREADY & sel_oh);
  assign slverr = |(apb.PSLVERR & sel_oh);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef APB_MGR_TIMEOUT_EN
    cnt_d    = '0;
`endif
    rreq_c   = 1'b0;
    wreq_c   = 1'b0;
    resp_c   = '0;
    psel_c   = '0;
    pen_c    = 1'b0;
    paddr_c  = '0;
    pwr_c    = 1'b0;
    pwdata_c = '0;
    unique case (state_q)
      IDLE: begin
        if (!req_empty) state_d = FETCH;
      end
      FETCH: begin
        rreq_c = 1'b1;
        {wdata_d, addr_d, write_d} = req_data;
        state_d = SETUP;
      end
      SETUP: begin
        paddr_c  = addr_q;
        pwr_c    = write_q;
        pwdata_c = write_q ? wdata_q : '0;
        if (dec_ok) begin
          psel_c  = sel_oh;
          state_d = ACCESS;
        end else begin
          rdata_d = '0;
          err_d   = 2'b10;
          state_d = RESP;
        end
      end
      ACCESS: begin
        psel_c   = sel_oh;
        pen_c    = 1'b1;
        paddr_c  = addr_q;
        pwr_c    = write_q;
        pwdata_c = write_q ? wdata_q : '0;
        if (rdy) begin
          rdata_d = write_q ? '0 : apb.PRDATA;
          err_d   = {1'b0, slverr};
          state_d = RESP;
        end
`ifdef APB_MGR_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = '0;
          err_d   = 2'b11;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (!resp_full) begin
          wreq_c  = 1'b1;
          resp_c  = {err_q, rdata_q};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= '0;
`ifdef APB_MGR_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_MGR_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // outputs forced quiet while reset is asserted, whatever the state
  assign req_rreq    = !PRESET && rreq_c;
  assign resp_wreq   = !PRESET && wreq_c;
  assign resp_data   = PRESET ? '0 : resp_c;
  assign busy        = !PRESET && (state_q != IDLE);
  assign apb.PSEL    = PRESET ? '0 : psel_c;
  assign apb.PENABLE = !PRESET && pen_c;
  assign apb.PADDR   = PRESET ? '0 : paddr_c;
  assign apb.PWRITE  = !PRESET && pwr_c;
  assign apb.PWDATA  = PRESET ? '0 : pwdata_c;
endmodule

// File: tb/tb_apb_multi_manager.sv
// Randomized scoreboard bench for apb_multi_manager (NUM_SLV=3 so that
// index 3 exercises the decode error); honours APB_MGR_TIMEOUT_EN.
module tb_apb_multi_manager;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NS = 3;
  localparam int TO = 16;
  localparam int RW = 1 + AW + DW;

  typedef struct {
    logic [RW-1:0]   word;
    int              waits;
    bit              slverr;
    logic [DW-1:0]   prdata;
    logic [DW+1:0]   exp;
  } txn_t;

  logic          clk = 1'b0;
  logic          PRESET = 1'b1;
  logic [RW-1:0] req_data = '0;
  logic          req_empty = 1'b1;
  logic          req_rreq;
  logic [DW+1:0] resp_data;
  logic          resp_full = 1'b0;
  logic          resp_wreq;
  logic          busy;

  apb_multi_manager_if #(.ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS)) apb();

  apb_multi_manager #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT_CYC(TO)
  ) dut (
    .PCLK(clk), .PRESET(PRESET),
    .req_data(req_data), .req_empty(req_empty), .req_rreq(req_rreq),
    .resp_data(resp_data), .resp_full(resp_full), .resp_wreq(resp_wreq),
    .busy(busy), .apb(apb)
  );

  always #5 clk = ~clk;

  txn_t fifo[$];
  txn_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_gap = 0;
  bit   rand_full = 0;
  int   full_hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slv_of(txn_t t);
    return int'(t.word[AW -: 2]);
  endfunction

  // expected response from the transfer rules
  function automatic logic [DW+1:0] model(txn_t t);
    if (slv_of(t) >= NS) return {2'b10, {DW{1'b0}}};
`ifdef APB_MGR_TIMEOUT_EN
    if (t.waits >= TO) return {2'b11, {DW{1'b0}}};
`endif
    return {1'b0, t.slverr, (t.word[0] ? {DW{1'b0}} : t.prdata)};
  endfunction

  // number of cycles with PENABLE high
  function automatic int acc_cycles(txn_t t);
    if (slv_of(t) >= NS) return 0;
`ifdef APB_MGR_TIMEOUT_EN
    if (t.waits >= TO) return TO;
`endif
    return t.waits + 1;
  endfunction

  task automatic issue(input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input int waits,
                       input bit se, input logic [DW-1:0] rd);
    txn_t t;
    t.word   = {wd, addr, wr};
    t.waits  = waits;
    t.slverr = se;
    t.prdata = rd;
    t.exp    = model(t);
    fifo.push_back(t);
    sb_q.push_back(t);
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((sb_q.size() > 0 || fifo.size() > 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
  endtask

  // request FIFO and completer models
  initial begin
    txn_t cur;
    bit   pr;
    int   acc_n;
    int   idx;
    logic [63:0] junk;
    cur.word = '0; cur.waits = 0; cur.slverr = 0;
    cur.prdata = '0; cur.exp = '0;
    acc_n = 0;
    apb.PREADY = '0; apb.PSLVERR = '0; apb.PRDATA = '0;
    forever begin
      @(negedge clk);
      pr = req_rreq && !PRESET;
      @(posedge clk);
      #1;
      if (pr && fifo.size() > 0) begin
        cur = fifo.pop_front();
        acc_n = 0;
      end
      junk = {$urandom, $urandom};
      req_data  = fifo.size() > 0 ? fifo[0].word : junk[RW-1:0];
      req_empty = (fifo.size() == 0) ||
                  (rand_gap && $urandom_range(0, 3) == 0);
      if (full_hold > 0) begin
        resp_full = 1'b1;
        full_hold--;
      end else begin
        resp_full = rand_full && ($urandom_range(0, 2) == 0);
      end
      apb.PREADY  = NS'($urandom);
      apb.PSLVERR = NS'($urandom);
      apb.PRDATA  = $urandom;
      idx = slv_of(cur);
      if (idx < NS && apb.PSEL[idx] && apb.PENABLE) begin
        acc_n++;
        apb.PREADY[idx] = (acc_n > cur.waits);
        if (acc_n > cur.waits) begin
          apb.PSLVERR[idx] = cur.slverr;
          apb.PRDATA = cur.prdata;
        end
      end else begin
        acc_n = 0;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    txn_t cur;
    bit   infl = 0;
    int   t0 = 0;
    int   o, acc, lat, idx;
    logic [NS-1:0] oh;
    logic [DW-1:0] wd_exp;
    forever begin
      @(negedge clk);
      if (PRESET) begin
        chk("reset_ctrl", {req_rreq, resp_wreq, resp_data, busy,
                           apb.PSEL, apb.PENABLE}, '0);
        chk("reset_bus", {apb.PADDR, apb.PWRITE, apb.PWDATA}, '0);
        if (infl) begin
          void'(sb_q.pop_front());
          infl = 0;
        end
      end else begin
        if (infl) begin
          chk("no_fetch_while_busy", req_rreq, 0);
        end else if (req_rreq) begin
          if (sb_q.size() == 0) begin
            chk("fetch_without_request", req_rreq, 0);
          end else begin
            cur  = sb_q[0];
            infl = 1;
            t0   = cyc;
          end
        end
        chk("busy", busy, infl);
        if (!infl) begin
          chk("idle_apb", {apb.PSEL, apb.PENABLE, apb.PADDR,
                           apb.PWRITE, apb.PWDATA}, '0);
          chk("idle_resp", {resp_wreq, resp_data}, '0);
        end else begin
          o      = cyc - t0;
          acc    = acc_cycles(cur);
          lat    = 2 + acc;
          idx    = slv_of(cur);
          oh     = (idx < NS) ? NS'(1) << idx : '0;
          wd_exp = cur.word[0] ? cur.word[RW-1:AW+1] : '0;
          if (o == 1 || (o >= 2 && o < 2 + acc)) begin
            chk("apb_phase",
                {apb.PSEL, apb.PENABLE, apb.PADDR, apb.PWRITE, apb.PWDATA},
                {oh, (o >= 2), cur.word[AW:1], cur.word[0], wd_exp});
          end else begin
            chk("apb_quiet", {apb.PSEL, apb.PENABLE}, '0);
          end
          chk("resp_wreq_timing", resp_wreq, (o >= lat) && !resp_full);
          if (resp_wreq) begin
            chk("resp_data", resp_data, cur.exp);
            void'(sb_q.pop_front());
            infl = 0;
          end
        end
        if (!resp_wreq) chk("resp_data_zero", resp_data, '0);
      end
    end
  end

  // stimulus
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 PRESET = 1'b0;
    @(posedge clk);
    #2;
    issue(1, 14'h0010, 32'hDEADBEEF, 0, 0, $urandom);
    drain(200);
    issue(0, {2'd2, 12'h004}, $urandom, 3, 0, 32'h12345678);
    drain(200);
    full_hold = 10;
    issue(0, {2'd1, 12'h0A0}, $urandom, 0, 1, $urandom);
    drain(200);
    issue(0, {2'd3, 12'h123}, $urandom, 0, 0, $urandom);
    issue(1, {2'd3, 12'h456}, $urandom, 0, 1, $urandom);
    drain(200);
    issue(0, {2'd0, 12'h777}, $urandom, 25, 0, 32'hCAFEF00D);
    drain(300);

    rand_gap  = 1;
    rand_full = 1;
    for (int k = 0; k < 60; k++) begin
      int w;
      w = ($urandom_range(0, 9) == 0) ? $urandom_range(17, 22)
                                      : $urandom_range(0, 4);
      issue($urandom_range(0, 1) == 1, AW'($urandom), $urandom, w,
            $urandom_range(0, 3) == 0, $urandom);
    end
    drain(5000);

    rand_gap  = 0;
    rand_full = 0;
    issue(0, {2'd0, 12'h010}, $urandom, 10, 0, $urandom);
    issue(1, {2'd2, 12'h020}, 32'h0BADF00D, 1, 0, $urandom);
    n = 0;
    while (!apb.PENABLE && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!apb.PENABLE) begin
      errors++;
      $display("FAIL reach_access actual=%0d required=1", apb.PENABLE);
    end
    @(posedge clk);
    #1 PRESET = 1'b1;
    @(posedge clk);
    #1 PRESET = 1'b0;
    drain(300);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
